// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite encodings and per-master FSM states shared by the s1 arbiter
package ahb_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] ST_IDLE       = 2'b00;
    localparam logic [1:0] ST_PEND       = 2'b01;
    localparam logic [1:0] ST_ISSUED     = 2'b10;
    localparam logic [1:0] ST_DATA       = 2'b11;

    function automatic logic is_xfer(logic [1:0] t);
        return t != HTRANS_IDLE && t != HTRANS_BUSY;
    endfunction
endpackage

// File: rtl/ahb_s1_port.sv
// ahb_s1_port: per-master capture FSM, pending buffer and response generation
module ahb_s1_port
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hsel,
    input  logic [1:0]        htrans,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [2:0]        hsize,
    input  logic [3:0]        hprot,
    input  logic              hwrite,
    input  logic              hready_s1,
    input  logic [DATA_W-1:0] hrdata_s1,
    input  logic [1:0]        hresp_s1,
    input  logic              grant,
    output logic              req,
    output logic              data_ph,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [2:0]        buf_size,
    output logic [3:0]        buf_prot,
    output logic              buf_write,
    output logic              hready,
    output logic [DATA_W-1:0] hrdata,
    output logic [1:0]        hresp
);
    logic [1:0] state, state_nx;
    logic       cap;

    assign req     = state == ST_PEND;
    assign data_ph = state == ST_DATA;
    assign hready  = state == ST_IDLE ? 1'b1 : data_ph ? hready_s1 : 1'b0;
    assign hrdata  = data_ph ? hrdata_s1 : '0;
    assign hresp   = data_ph ? hresp_s1 : HRESP_OKAY;
    // cap implies hready, so it can only fire from IDLE or a completing DATA
    assign cap     = hready && hsel && is_xfer(htrans);

    always_comb begin
        state_nx = cap                               ? ST_PEND   :
                   data_ph && hready_s1              ? ST_IDLE   :
                   req && grant                      ? ST_ISSUED :
                   state == ST_ISSUED && hready_s1   ? ST_DATA   : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            buf_addr  <= '0;
            buf_size  <= '0;
            buf_prot  <= '0;
            buf_write <= 1'b0;
        end else begin
            state <= state_nx;
            if (cap) begin
                buf_addr  <= haddr;
                buf_size  <= hsize;
                buf_prot  <= hprot;
                buf_write <= hwrite;
            end
        end
    end
endmodule

// File: rtl/ahb_s1_arbiter.sv
// ahb_s1_arbiter: two-master round-robin AHB-Lite arbiter in front of the s1 slave
module ahb_s1_arbiter
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              pll_core_cpuclk,
    input  logic              pad_cpu_rst_b,
    input  logic              hsel_m0,
    input  logic [1:0]        htrans_m0,
    input  logic [ADDR_W-1:0] haddr_m0,
    input  logic [2:0]        hsize_m0,
    input  logic [2:0]        hburst_m0,
    input  logic [3:0]        hprot_m0,
    input  logic              hwrite_m0,
    input  logic [DATA_W-1:0] hwdata_m0,
    output logic [DATA_W-1:0] hrdata_m0,
    output logic              hready_m0,
    output logic [1:0]        hresp_m0,
    input  logic              hsel_m1,
    input  logic [1:0]        htrans_m1,
    input  logic [ADDR_W-1:0] haddr_m1,
    input  logic [2:0]        hsize_m1,
    input  logic [2:0]        hburst_m1,
    input  logic [3:0]        hprot_m1,
    input  logic              hwrite_m1,
    input  logic [DATA_W-1:0] hwdata_m1,
    output logic [DATA_W-1:0] hrdata_m1,
    output logic              hready_m1,
    output logic [1:0]        hresp_m1,
    output logic              hsel_s1,
    output logic [1:0]        htrans_s1,
    output logic [ADDR_W-1:0] haddr_s1,
    output logic [2:0]        hsize_s1,
    output logic [2:0]        hburst_s1,
    output logic [3:0]        hprot_s1,
    output logic              hwrite_s1,
    output logic [DATA_W-1:0] hwdata_s1,
    input  logic [DATA_W-1:0] hrdata_s1,
    input  logic              hready_s1,
    input  logic [1:0]        hresp_s1
);
    logic              req0, req1, data0, data1, win0, win1, last_grant;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [2:0]        size0, size1;
    logic [3:0]        prot0, prot1;
    logic              write0, write1;
    logic              unused_burst;

    // every issued transfer is re-cast as SINGLE, so master burst hints are dropped
    assign unused_burst = ^{hburst_m0, hburst_m1};
    assign hburst_s1    = HBURST_SINGLE;
    assign win0         = req0 && (!req1 || last_grant);
    assign win1         = req1 && (!req0 || !last_grant);
    assign hwdata_s1    = data0 ? hwdata_m0 : data1 ? hwdata_m1 : '0;

    ahb_s1_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port0 (
        .clk(pll_core_cpuclk), .rst_n(pad_cpu_rst_b), .hsel(hsel_m0), .htrans(htrans_m0),
        .haddr(haddr_m0), .hsize(hsize_m0), .hprot(hprot_m0), .hwrite(hwrite_m0),
        .hready_s1(hready_s1), .hrdata_s1(hrdata_s1), .hresp_s1(hresp_s1),
        .grant(win0 && hready_s1), .req(req0), .data_ph(data0), .buf_addr(addr0),
        .buf_size(size0), .buf_prot(prot0), .buf_write(write0),
        .hready(hready_m0), .hrdata(hrdata_m0), .hresp(hresp_m0)
    );

    ahb_s1_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port1 (
        .clk(pll_core_cpuclk), .rst_n(pad_cpu_rst_b), .hsel(hsel_m1), .htrans(htrans_m1),
        .haddr(haddr_m1), .hsize(hsize_m1), .hprot(hprot_m1), .hwrite(hwrite_m1),
        .hready_s1(hready_s1), .hrdata_s1(hrdata_s1), .hresp_s1(hresp_s1),
        .grant(win1 && hready_s1), .req(req1), .data_ph(data1), .buf_addr(addr1),
        .buf_size(size1), .buf_prot(prot1), .buf_write(write1),
        .hready(hready_m1), .hrdata(hrdata_m1), .hresp(hresp_m1)
    );

    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            last_grant <= 1'b1;
            hsel_s1    <= 1'b0;
            htrans_s1  <= HTRANS_IDLE;
            haddr_s1   <= '0;
            hsize_s1   <= '0;
            hprot_s1   <= '0;
            hwrite_s1  <= 1'b0;
        end else if (hready_s1) begin
            if (win0 || win1)
                last_grant <= win1;
            hsel_s1   <= win0 || win1;
            htrans_s1 <= win0 || win1 ? HTRANS_NONSEQ : HTRANS_IDLE;
            haddr_s1  <= win0 ? addr0 : win1 ? addr1 : '0;
            hsize_s1  <= win0 ? size0 : win1 ? size1 : '0;
            hprot_s1  <= win0 ? prot0 : win1 ? prot1 : '0;
            hwrite_s1 <= win0 ? write0 : win1 ? write1 : 1'b0;
        end
    end
endmodule

// File: tb/tb_ahb_s1_arbiter.sv
// tb_ahb_s1_arbiter: directed checks of capture, round-robin, wait states and reset
module tb_ahb_s1_arbiter;
    logic        clk = 1'b0, rst_n;
    logic        hsel_m0, hwrite_m0, hsel_m1, hwrite_m1;
    logic [1:0]  htrans_m0, htrans_m1, hresp_m0, hresp_m1, htrans_s1, hresp_s1;
    logic [31:0] haddr_m0, haddr_m1, hwdata_m0, hwdata_m1, hrdata_m0, hrdata_m1;
    logic [2:0]  hsize_m0, hsize_m1, hburst_m0, hburst_m1, hsize_s1, hburst_s1;
    logic [3:0]  hprot_m0, hprot_m1, hprot_s1;
    logic        hready_m0, hready_m1, hsel_s1, hwrite_s1, hready_s1;
    logic [31:0] haddr_s1, hwdata_s1, hrdata_s1;
    int          checks = 0, errors = 0;

    ahb_s1_arbiter dut (
        .pll_core_cpuclk(clk), .pad_cpu_rst_b(rst_n),
        .hsel_m0(hsel_m0), .htrans_m0(htrans_m0), .haddr_m0(haddr_m0), .hsize_m0(hsize_m0),
        .hburst_m0(hburst_m0), .hprot_m0(hprot_m0), .hwrite_m0(hwrite_m0), .hwdata_m0(hwdata_m0),
        .hrdata_m0(hrdata_m0), .hready_m0(hready_m0), .hresp_m0(hresp_m0),
        .hsel_m1(hsel_m1), .htrans_m1(htrans_m1), .haddr_m1(haddr_m1), .hsize_m1(hsize_m1),
        .hburst_m1(hburst_m1), .hprot_m1(hprot_m1), .hwrite_m1(hwrite_m1), .hwdata_m1(hwdata_m1),
        .hrdata_m1(hrdata_m1), .hready_m1(hready_m1), .hresp_m1(hresp_m1),
        .hsel_s1(hsel_s1), .htrans_s1(htrans_s1), .haddr_s1(haddr_s1), .hsize_s1(hsize_s1),
        .hburst_s1(hburst_s1), .hprot_s1(hprot_s1), .hwrite_s1(hwrite_s1), .hwdata_s1(hwdata_s1),
        .hrdata_s1(hrdata_s1), .hready_s1(hready_s1), .hresp_s1(hresp_s1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #2;
    endtask

    task automatic m0(input logic s, input logic [1:0] t, input logic [31:0] a, input logic w);
        hsel_m0 = s; htrans_m0 = t; haddr_m0 = a; hwrite_m0 = w;
    endtask

    task automatic m1(input logic s, input logic [1:0] t, input logic [31:0] a, input logic w);
        hsel_m1 = s; htrans_m1 = t; haddr_m1 = a; hwrite_m1 = w;
    endtask

    task automatic quiet();
        m0(1'b0, 2'b00, 32'h0, 1'b0);
        m1(1'b0, 2'b00, 32'h0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b1;
        quiet();
        hsize_m0 = 3'd2; hsize_m1 = 3'd2; hburst_m0 = 3'd1; hburst_m1 = 3'd3;
        hprot_m0 = 4'h3; hprot_m1 = 4'h3; hwdata_m0 = '0; hwdata_m1 = '0;
        hready_s1 = 1'b0; hrdata_s1 = '0; hresp_s1 = 2'b00;
        #1 rst_n = 1'b0;
        #2;
        check("rst_hsel_s1", hsel_s1, 0);
        check("rst_htrans_s1", htrans_s1, 0);
        check("rst_haddr_s1", haddr_s1, 0);
        check("rst_hready_m0", hready_m0, 1);
        check("rst_hready_m1", hready_m1, 1);
        check("rst_hresp_m0", hresp_m0, 0);
        check("rst_hrdata_m0", hrdata_m0, 0);
        check("rst_hwdata_s1", hwdata_s1, 0);
        tick(); tick();
        rst_n = 1'b1; hready_s1 = 1'b1;

        // single m0 read, zero-wait slave
        tick(); m0(1'b1, 2'b10, 32'h100, 1'b0); look();
        check("t1_c0_hready_m0", hready_m0, 1);
        tick(); quiet(); look();
        check("t1_c1_hready_m0", hready_m0, 0);
        check("t1_c1_htrans_s1", htrans_s1, 0);
        tick(); look();
        check("t1_c2_htrans_s1", htrans_s1, 2);
        check("t1_c2_haddr_s1", haddr_s1, 32'h100);
        check("t1_c2_hsel_s1", hsel_s1, 1);
        check("t1_c2_hwrite_s1", hwrite_s1, 0);
        check("t1_c2_hburst_s1", hburst_s1, 0);
        check("t1_c2_hsize_s1", hsize_s1, 2);
        check("t1_c2_hprot_s1", hprot_s1, 3);
        check("t1_c2_hready_m0", hready_m0, 0);
        tick(); hrdata_s1 = 32'hDEADBEEF; look();
        check("t1_c3_hready_m0", hready_m0, 1);
        check("t1_c3_hrdata_m0", hrdata_m0, 32'hDEADBEEF);
        check("t1_c3_hrdata_m1", hrdata_m1, 0);
        check("t1_c3_htrans_s1", htrans_s1, 0);
        tick(); look();
        check("t1_c4_hrdata_m0", hrdata_m0, 0);
        hrdata_s1 = '0;

        // m1 write with ERROR passed through
        tick(); m1(1'b1, 2'b10, 32'h200, 1'b1); look();
        check("t2_c0_hready_m1", hready_m1, 1);
        tick(); quiet(); hwdata_m1 = 32'h12345678; look();
        check("t2_c1_hready_m1", hready_m1, 0);
        tick(); look();
        check("t2_c2_hwrite_s1", hwrite_s1, 1);
        check("t2_c2_haddr_s1", haddr_s1, 32'h200);
        check("t2_c2_hready_m1", hready_m1, 0);
        check("t2_c2_hwdata_s1", hwdata_s1, 0);
        tick(); hresp_s1 = 2'b01; look();
        check("t2_c3_hwdata_s1", hwdata_s1, 32'h12345678);
        check("t2_c3_hready_m1", hready_m1, 1);
        check("t2_c3_hresp_m1", hresp_m1, 1);
        check("t2_c3_hresp_m0", hresp_m0, 0);
        tick(); hresp_s1 = 2'b00; hwdata_m1 = '0; look();
        check("t2_c4_hwdata_s1", hwdata_s1, 0);

        // simultaneous requests after reset
        rst_n = 1'b0; hready_s1 = 1'b0;
        tick(); rst_n = 1'b1; hready_s1 = 1'b1;
        tick(); m0(1'b1, 2'b10, 32'h300, 1'b0); m1(1'b1, 2'b10, 32'h400, 1'b0);
        tick(); quiet(); look();
        check("t3_c1_hready_m0", hready_m0, 0);
        check("t3_c1_hready_m1", hready_m1, 0);
        tick(); look();
        check("t3_first_m0", haddr_s1, 32'h300);
        tick(); look();
        check("t3_next_m1", haddr_s1, 32'h400);
        check("t3_c3_hready_m0", hready_m0, 1);
        tick(); look();
        check("t3_c4_hready_m1", hready_m1, 1);
        check("t3_c4_htrans_s1", htrans_s1, 0);
        tick(); m0(1'b1, 2'b10, 32'h700, 1'b0);
        tick(); quiet();
        tick(); look();
        check("t3_solo_m0", haddr_s1, 32'h700);
        tick(); m0(1'b1, 2'b10, 32'h800, 1'b0); m1(1'b1, 2'b10, 32'h900, 1'b0); look();
        check("t3_c8_hready_m0", hready_m0, 1);
        tick(); quiet();
        tick(); look();
        check("t3_tie_m1_wins", haddr_s1, 32'h900);
        tick(); look();
        check("t3_then_m0", haddr_s1, 32'h800);
        check("t3_c11_hready_m1", hready_m1, 1);
        check("t3_c11_hready_m0", hready_m0, 0);
        tick(); look();
        check("t3_c12_hready_m0", hready_m0, 1);
        check("t3_c12_htrans_s1", htrans_s1, 0);
        tick();

        // slave wait states
        tick(); m0(1'b1, 2'b10, 32'h1000, 1'b0);
        tick(); quiet();
        tick(); m1(1'b1, 2'b10, 32'hA00, 1'b0); look();
        check("t4_c2_haddr_s1", haddr_s1, 32'h1000);
        check("t4_c2_hready_m1", hready_m1, 1);
        tick(); quiet(); hready_s1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            look();
            check("t4_wait_hready_m0", hready_m0, 0);
            check("t4_wait_hready_m1", hready_m1, 0);
            check("t4_wait_htrans_s1", htrans_s1, 0);
        end
        tick(); hready_s1 = 1'b1; hrdata_s1 = 32'hCAFEF00D; look();
        check("t4_c6_hready_m0", hready_m0, 1);
        check("t4_c6_hrdata_m0", hrdata_m0, 32'hCAFEF00D);
        tick(); hready_s1 = 1'b0; hrdata_s1 = '0; look();
        check("t4_c7_haddr_s1", haddr_s1, 32'hA00);
        check("t4_c7_htrans_s1", htrans_s1, 2);
        tick(); look();
        check("t4_c8_haddr_hold", haddr_s1, 32'hA00);
        check("t4_c8_hready_m1", hready_m1, 0);
        tick(); hready_s1 = 1'b1; look();
        check("t4_c9_haddr_hold", haddr_s1, 32'hA00);
        check("t4_c9_hready_m1", hready_m1, 0);
        tick(); look();
        check("t4_c10_hready_m1", hready_m1, 1);
        check("t4_c10_htrans_s1", htrans_s1, 0);
        tick();

        // filtering of IDLE/BUSY and deselected transfers
        tick(); m0(1'b1, 2'b00, 32'h40, 1'b0); m1(1'b1, 2'b01, 32'h44, 1'b0); look();
        check("t5_idle_hready_m0", hready_m0, 1);
        check("t5_busy_hready_m1", hready_m1, 1);
        tick(); m0(1'b0, 2'b10, 32'h48, 1'b0); m1(1'b0, 2'b11, 32'h4C, 1'b0); look();
        check("t5_c1_hsel_s1", hsel_s1, 0);
        check("t5_c1_hready_m0", hready_m0, 1);
        check("t5_c1_hready_m1", hready_m1, 1);
        tick(); quiet(); look();
        check("t5_c2_hsel_s1", hsel_s1, 0);
        check("t5_c2_hready_m0", hready_m0, 1);
        check("t5_c2_hready_m1", hready_m1, 1);
        tick(); look();
        check("t5_c3_hsel_s1", hsel_s1, 0);
        check("t5_c3_htrans_s1", htrans_s1, 0);

        // reset while m0 is ISSUED
        tick(); m0(1'b1, 2'b10, 32'h500, 1'b0);
        tick(); quiet();
        tick(); look();
        check("t6_issued_htrans_s1", htrans_s1, 2);
        check("t6_issued_hready_m0", hready_m0, 0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_hsel_s1", hsel_s1, 0);
        check("t6_rst_htrans_s1", htrans_s1, 0);
        check("t6_rst_haddr_s1", haddr_s1, 0);
        check("t6_rst_hready_m0", hready_m0, 1);
        check("t6_rst_hwdata_s1", hwdata_s1, 0);
        #1 rst_n = 1'b1;
        tick(); look();
        check("t6_after_htrans_s1", htrans_s1, 0);
        check("t6_after_hready_m0", hready_m0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
